fpu_addsub_cfg: RTL and testbench

//  Multi-cycle IEEE-754 floating-point add/subtract unit with run-time add/sub select, five

---
 rtl/fpu_addsub_cfg.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_fpu_addsub_cfg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_cfg.sv
// Multi-cycle IEEE-754 add/subtract with run-time op select, five rounding modes and flags.
module fpu_addsub_cfg #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   din1,
  input  logic [EXP_W+MAN_W:0]   din2,
  input  logic                   op,
  input  logic [2:0]             rnd_mode,
  input  logic                   dval,
  output logic                   busy,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [4:0]             flags,
  output logic                   rdy
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned MX  = MAN_W + 5;   // carry + hidden + mantissa + G/R/S
  localparam int unsigned HB  = MAN_W + 3;   // hidden-bit position
  localparam int unsigned EW1 = EXP_W + 1;   // one spare bit for overflow detection

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]     rm_q, rm_d;
  logic [EW1-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [MX-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic [MX-1:0]  mx_q, mx_d, my_q, my_d;
  logic [EW1-1:0] ex_q, ex_d, cnt_q, cnt_d;
  logic           sx_q, sx_d, sy_q, sy_d;
  logic [MAN_W:0] rmant_q, rmant_d;
  logic           nx_q, nx_d;
  logic [W-1:0]   res_q, res_d, result_q, result_d;
  logic [4:0]     flg_q, flg_d, flags_q, flags_d;
  logic           rdy_q, rdy_d, busy_q, busy_d;

  // Operand classification of the captured operands
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign a_exp  = a_q[W-2:MAN_W];
  assign b_exp  = b_q[W-2:MAN_W];
  assign a_man  = a_q[MAN_W-1:0];
  assign b_man  = b_q[MAN_W-1:0];
  assign a_nan  = (&a_exp) && (|a_man);
  assign b_nan  = (&b_exp) && (|b_man);
  assign a_snan = a_nan && !a_man[MAN_W-1];
  assign b_snan = b_nan && !b_man[MAN_W-1];
  assign a_inf  = (&a_exp) && !(|a_man);
  assign b_inf  = (&b_exp) && !(|b_man);
  assign a_zero = !(|a_exp) && !(|a_man);
  assign b_zero = !(|b_exp) && !(|b_man);

  // Magnitude add/subtract of aligned mantissas
  logic          same_sgn, x_ge_y, add_sgn;
  logic [MX-1:0] add_raw;

  assign same_sgn = (sx_q == sy_q);
  assign x_ge_y   = (mx_q >= my_q);
  assign add_raw  = same_sgn ? (mx_q + my_q) : (x_ge_y ? (mx_q - my_q) : (my_q - mx_q));
  assign add_sgn  = (same_sgn || x_ge_y) ? sx_q : sy_q;

  // Rounding increment from guard/round/sticky
  logic           rnd_g, rnd_r, rnd_s, rnd_lsb, rnd_nx, rnd_inc;
  logic [MAN_W+1:0] rnd_sum;

  assign rnd_lsb = mx_q[3];
  assign rnd_g   = mx_q[2];
  assign rnd_r   = mx_q[1];
  assign rnd_s   = mx_q[0];
  assign rnd_nx  = rnd_g | rnd_r | rnd_s;

  always_comb begin
    rnd_inc = 1'b0;
    case (rm_q)
      RM_RTZ:  rnd_inc = 1'b0;
      RM_RDN:  rnd_inc = sx_q & rnd_nx;
      RM_RUP:  rnd_inc = !sx_q & rnd_nx;
      RM_RMM:  rnd_inc = rnd_g;
      default: rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_lsb);
    endcase
  end

  assign rnd_sum = {1'b0, mx_q[HB:3]} + (MAN_W+2)'(rnd_inc);

  // Overflow direction for the result sign and rounding mode
  logic ovf_to_inf;
  assign ovf_to_inf = (rm_q == RM_RNE) || (rm_q == RM_RMM) ||
                      ((rm_q == RM_RDN) && sx_q) || ((rm_q == RM_RUP) && !sx_q);

  // Next-state and datapath for every FSM step
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rm_d     = rm_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    mx_d     = mx_q;
    my_d     = my_q;
    ex_d     = ex_q;
    cnt_d    = cnt_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    rmant_d  = rmant_q;
    nx_d     = nx_q;
    res_d    = res_q;
    flg_d    = flg_q;
    result_d = result_q;
    flags_d  = flags_q;
    rdy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dval && !busy_q) begin
          a_d     = din1;
          b_d     = {din2[W-1] ^ op, din2[W-2:0]};
          rm_d    = (rnd_mode > RM_RMM) ? RM_RNE : rnd_mode;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        ea_d    = (a_exp == '0) ? EW1'(1) : {1'b0, a_exp};
        eb_d    = (b_exp == '0) ? EW1'(1) : {1'b0, b_exp};
        ma_d    = {1'b0, |a_exp, a_man, 3'b000};
        mb_d    = {1'b0, |b_exp, b_man, 3'b000};
        state_d = S_SPECIAL;
      end

      S_SPECIAL: begin
        flg_d   = 5'b0;
        state_d = S_DONE;
        if (a_nan || b_nan) begin
          res_d    = QNAN;
          flg_d[4] = a_snan | b_snan;
        end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
          res_d    = QNAN;
          flg_d[4] = 1'b1;
        end else if (a_inf) begin
          res_d = a_q;
        end else if (b_inf) begin
          res_d = b_q;
        end else if (a_zero && b_zero) begin
          res_d = {(a_q[W-1] == b_q[W-1]) ? a_q[W-1] : (rm_q == RM_RDN), {(W-1){1'b0}}};
        end else if (a_zero) begin
          res_d = b_q;
        end else if (b_zero) begin
          res_d = a_q;
        end else begin
          if (ea_q >= eb_q) begin
            mx_d  = ma_q;  my_d = mb_q;
            ex_d  = ea_q;  cnt_d = ea_q - eb_q;
            sx_d  = a_q[W-1];  sy_d = b_q[W-1];
          end else begin
            mx_d  = mb_q;  my_d = ma_q;
            ex_d  = eb_q;  cnt_d = eb_q - ea_q;
            sx_d  = b_q[W-1];  sy_d = a_q[W-1];
          end
          state_d = (cnt_d == '0) ? S_ADD : S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (cnt_q > EW1'(MAN_W + 3)) begin
          my_d    = {{(MX-1){1'b0}}, |my_q};
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          my_d  = {1'b0, my_q[MX-1:2], my_q[1] | my_q[0]};
          cnt_d = cnt_q - EW1'(1);
          if (cnt_q == EW1'(1)) state_d = S_ADD;
        end
      end

      S_ADD: begin
        sx_d = (add_raw == '0) ? (rm_q == RM_RDN) : add_sgn;
        if (add_raw[MX-1]) begin
          mx_d = {1'b0, add_raw[MX-1:2], add_raw[1] | add_raw[0]};
          ex_d = ex_q + EW1'(1);
        end else begin
          mx_d = add_raw;
        end
        state_d = S_NORM;
      end

      S_NORM: begin
        if (mx_q[HB] || (ex_q == EW1'(1))) begin
          state_d = S_ROUND;
        end else begin
          mx_d = {mx_q[MX-2:0], 1'b0};
          ex_d = ex_q - EW1'(1);
        end
      end

      S_ROUND: begin
        nx_d = rnd_nx;
        if (rnd_sum[MAN_W+1]) begin
          rmant_d = rnd_sum[MAN_W+1:1];
          ex_d    = ex_q + EW1'(1);
        end else begin
          rmant_d = rnd_sum[MAN_W:0];
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        if (ex_q >= {1'b0, {EXP_W{1'b1}}}) begin
          res_d = ovf_to_inf ? {sx_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {sx_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          flg_d = 5'b00101;
        end else begin
          res_d = {sx_q, rmant_q[MAN_W] ? ex_q[EXP_W-1:0] : {EXP_W{1'b0}}, rmant_q[MAN_W-1:0]};
          flg_d = {4'b0000, nx_q};
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        result_d = res_q;
        flags_d  = flg_q;
        rdy_d    = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || rdy_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      ea_q     <= '0;
      eb_q     <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      ex_q     <= '0;
      cnt_q    <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      rmant_q  <= '0;
      nx_q     <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rm_q     <= rm_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      ex_q     <= ex_d;
      cnt_q    <= cnt_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      rmant_q  <= rmant_d;
      nx_q     <= nx_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign rdy    = rdy_q;

endmodule

// File: tb/tb_fpu_addsub_cfg.sv
// Directed vector bench for fpu_addsub_cfg (binary32 and binary64 instances).
module tb_fpu_addsub_cfg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // binary32 instance
  logic [31:0] d1, d2, res;
  logic        op, dval, busy, rdy;
  logic [2:0]  rm;
  logic [4:0]  flg;

  fpu_addsub_cfg dut32 (
    .clk(clk), .rst(rst), .din1(d1), .din2(d2), .op(op), .rnd_mode(rm),
    .dval(dval), .busy(busy), .result(res), .flags(flg), .rdy(rdy)
  );

  // binary64 instance
  logic [63:0] d1w, d2w, resw;
  logic        opw, dvalw, busyw, rdyw;
  logic [2:0]  rmw;
  logic [4:0]  flgw;

  fpu_addsub_cfg #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst(rst), .din1(d1w), .din2(d2w), .op(opw), .rnd_mode(rmw),
    .dval(dvalw), .busy(busyw), .result(resw), .flags(flgw), .rdy(rdyw)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        o;
    logic [2:0]  m;
    logic [31:0] r;
    logic [4:0]  f;
    int          maxlat;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d cycles, limit %0d", nm, act, lim);
    end
  endtask

  task automatic av(input logic [31:0] a, input logic [31:0] b, input logic o,
                    input logic [2:0] m, input logic [31:0] r, input logic [4:0] f,
                    input int ml);
    vec_t v;
    v.a = a; v.b = b; v.o = o; v.m = m; v.r = r; v.f = f; v.maxlat = ml;
    vq.push_back(v);
  endtask

  // Issue one binary32 request and wait (bounded) for its completion
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [2:0] m, output logic [31:0] r, output logic [4:0] f,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    d1 = a; d2 = b; op = o; rm = m; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    lat = 0;
    while (!rdy && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res;
    f = flg;
  endtask

  localparam int SP = 5;                 // special-case latency
  localparam int NL = 2 * 23 + 14;       // general-path latency bound

  initial begin
    logic [31:0] r;
    logic [4:0]  f;
    int          lat, pulses, guard;

    rst = 1'b1; dval = 1'b0; d1 = '0; d2 = '0; op = 1'b0; rm = '0;
    dvalw = 1'b0; d1w = '0; d2w = '0; opw = 1'b0; rmw = '0;

    // Vector table
    av(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 5'h00, NL);
    av(32'h3F800000, 32'h40000000, 1'b1, 3'd0, 32'hBF800000, 5'h00, NL);
    av(32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7FC00000, 5'h10, SP);
    av(32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h10, SP);
    av(32'h7FC00000, 32'h7F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h00, SP);
    av(32'hFF800000, 32'h3F800000, 1'b0, 3'd0, 32'hFF800000, 5'h00, SP);
    av(32'h7F800000, 32'h7F800000, 1'b0, 3'd0, 32'h7F800000, 5'h00, SP);
    av(32'h3F800000, 32'h00000000, 1'b0, 3'd0, 32'h3F800000, 5'h00, SP);
    av(32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 5'h00, SP);
    av(32'h00000000, 32'h00000000, 1'b1, 3'd0, 32'h00000000, 5'h00, SP);
    av(32'h00000000, 32'h00000000, 1'b1, 3'd2, 32'h80000000, 5'h00, SP);
    av(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 5'h05, NL);
    av(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 5'h05, NL);
    av(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 32'h7F7FFFFF, 5'h05, NL);
    av(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd3, 32'h7F800000, 5'h05, NL);
    av(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd4, 32'h7F800000, 5'h05, NL);
    av(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd2, 32'hFF800000, 5'h05, NL);
    av(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 32'hFF7FFFFF, 5'h05, NL);
    av(32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 5'h01, NL);
    av(32'h3F800000, 32'h33800000, 1'b0, 3'd1, 32'h3F800000, 5'h01, NL);
    av(32'h3F800000, 32'h33800000, 1'b0, 3'd2, 32'h3F800000, 5'h01, NL);
    av(32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 5'h01, NL);
    av(32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 5'h01, NL);
    av(32'h3F800000, 32'h33800000, 1'b0, 3'd7, 32'h3F800000, 5'h01, NL);
    av(32'h3F800001, 32'h33800000, 1'b0, 3'd0, 32'h3F800002, 5'h01, NL);
    av(32'hBF800000, 32'hB3800000, 1'b0, 3'd2, 32'hBF800001, 5'h01, NL);
    av(32'h3F800000, 32'h32800000, 1'b0, 3'd3, 32'h3F800001, 5'h01, NL);
    av(32'h3F800000, 32'h32800000, 1'b0, 3'd0, 32'h3F800000, 5'h01, NL);
    av(32'h3F800000, 32'h32000000, 1'b0, 3'd3, 32'h3F800001, 5'h01, NL);
    av(32'h3F800000, 32'h00000001, 1'b0, 3'd3, 32'h3F800001, 5'h01, NL);
    av(32'h00000001, 32'h00000001, 1'b1, 3'd0, 32'h00000000, 5'h00, NL);
    av(32'h00000001, 32'h00000001, 1'b1, 3'd2, 32'h80000000, 5'h00, NL);
    av(32'h00400000, 32'h00400000, 1'b0, 3'd0, 32'h00800000, 5'h00, NL);
    av(32'h3FC00000, 32'h3FC00000, 1'b0, 3'd0, 32'h40400000, 5'h00, NL);
    av(32'h3F800001, 32'h3F800000, 1'b1, 3'd0, 32'h34000000, 5'h00, NL);
    av(32'h3F800000, 32'h33800000, 1'b1, 3'd0, 32'h3F7FFFFF, 5'h00, NL);
    av(32'h00800000, 32'h00000001, 1'b1, 3'd0, 32'h007FFFFF, 5'h00, NL);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy",    64'(rdy),  64'd0);
    chk("reset_busy",   64'(busy), 64'd0);
    chk("reset_result", 64'(res),  64'd0);
    chk("reset_flags",  64'(flg),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vq[i]) begin
      run32(vq[i].a, vq[i].b, vq[i].o, vq[i].m, r, f, lat);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(vq[i].r));
      chk($sformatf("vec%0d_flags", i),  64'(f), 64'(vq[i].f));
      chk_le($sformatf("vec%0d_latency", i), lat, vq[i].maxlat);
    end

    // dval while busy is ignored; exactly one rdy; result held afterwards
    @(negedge clk);
    guard = 0;
    while (busy && guard < 300) begin @(negedge clk); guard++; end
    d1 = 32'h3F800000; d2 = 32'h40000000; op = 1'b0; rm = 3'd0; dval = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", 64'(busy), 64'd1);
    d1 = 32'h7F800001; d2 = 32'h7F800001;
    repeat (3) @(posedge clk);
    #1;
    dval = 1'b0;
    pulses = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (rdy) pulses++;
    end
    chk("ignored_dval_pulses", 64'(pulses), 64'd1);
    chk("ignored_dval_result", 64'(res),    64'h40400000);
    chk("ignored_dval_flags",  64'(flg),    64'h00);
    chk("idle_busy",           64'(busy),   64'd0);

    // Back-to-back: new request accepted in the cycle after rdy
    run32(32'h3F800000, 32'h3F800000, 1'b0, 3'd0, r, f, lat);
    chk("b2b_first", 64'(r), 64'h40000000);
    chk("rdy_cycle_busy", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("after_rdy_busy", 64'(busy), 64'd0);
    d1 = 32'h40000000; d2 = 32'h3F800000; op = 1'b1; rm = 3'd0; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    chk("b2b_accept_busy", 64'(busy), 64'd1);
    lat = 0;
    while (!rdy && lat < 300) begin @(posedge clk); #1; lat++; end
    chk("b2b_second", 64'(res), 64'h3F800000);
    chk_le("b2b_latency", lat, NL);

    // Reset pulse while aligning aborts without rdy
    @(negedge clk);
    guard = 0;
    while (busy && guard < 300) begin @(negedge clk); guard++; end
    d1 = 32'h3F800000; d2 = 32'h33800000; op = 1'b0; rm = 3'd0; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy",   64'(busy), 64'd0);
    chk("abort_rdy",    64'(rdy),  64'd0);
    chk("abort_result", 64'(res),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (rdy || busy) pulses++;
    end
    chk("abort_no_activity", 64'(pulses), 64'd0);
    run32(32'h3F800000, 32'h40000000, 1'b0, 3'd0, r, f, lat);
    chk("post_abort_result", 64'(r), 64'h40400000);

    // binary64 instance
    @(negedge clk);
    d1w = 64'h3FF0000000000000; d2w = 64'h4000000000000000; opw = 1'b0; rmw = 3'd0; dvalw = 1'b1;
    @(posedge clk); #1;
    dvalw = 1'b0;
    lat = 0;
    while (!rdyw && lat < 400) begin @(posedge clk); #1; lat++; end
    chk("dp_add_result", resw, 64'h4008000000000000);
    chk("dp_add_flags",  64'(flgw), 64'h00);
    chk_le("dp_add_latency", lat, 2 * 52 + 14);
    repeat (2) @(negedge clk);
    d1w = 64'h3FF0000000000000; d2w = 64'h4000000000000000; opw = 1'b1; dvalw = 1'b1;
    @(posedge clk); #1;
    dvalw = 1'b0;
    lat = 0;
    while (!rdyw && lat < 400) begin @(posedge clk); #1; lat++; end
    chk("dp_sub_result", resw, 64'hBFF0000000000000);
    chk_le("dp_sub_latency", lat, 2 * 52 + 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
